// File: rtl/trace_capture_buffer.sv
// Trace capture buffer: per-channel pending regs, round-robin arbiter, show-ahead FIFO.
// Define TRACE_FILTER_EN to suppress events repeating the channel's last idx/data.
module trace_capture_lane #(
   parameter int DATA_W = 128,
   parameter int IDX_W  = 10,
   parameter int TS_W   = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              valid_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [TS_W-1:0]   ts_i,
   input  logic              move_i,
   output logic              pend_vld_o,
   output logic [IDX_W-1:0]  pend_idx_o,
   output logic [DATA_W-1:0] pend_data_o,
   output logic [TS_W-1:0]   pend_ts_o,
   output logic              drop_o
);
   logic              vld_q, vld_d;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] data_q;
   logic [TS_W-1:0]   ts_q;
   logic              suppress, sample, busy, load;

`ifdef TRACE_FILTER_EN
   logic              last_vld_q;
   logic [IDX_W-1:0]  last_idx_q;
   logic [DATA_W-1:0] last_data_q;

   assign suppress = last_vld_q && (idx_i == last_idx_q) && (data_i == last_data_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_vld_q  <= 1'b0;
         last_idx_q  <= '0;
         last_data_q <= '0;
      end else if (sample) begin
         last_vld_q  <= 1'b1;
         last_idx_q  <= idx_i;
         last_data_q <= data_i;
      end
   end
`else
   assign suppress = 1'b0;
`endif

   assign sample = enable_i & valid_i & ~suppress;
   // A slot being moved this cycle is free for refill.
   assign busy   = vld_q & ~move_i;
   assign drop_o = sample & busy;
   assign load   = sample & ~busy;

   always_comb begin
      vld_d = vld_q;
      if (load)        vld_d = 1'b1;
      else if (move_i) vld_d = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q  <= 1'b0;
         idx_q  <= '0;
         data_q <= '0;
         ts_q   <= '0;
      end else begin
         vld_q <= vld_d;
         if (load) begin
            idx_q  <= idx_i;
            data_q <= data_i;
            ts_q   <= ts_i;
         end
      end
   end

   assign pend_vld_o  = vld_q;
   assign pend_idx_o  = idx_q;
   assign pend_data_o = data_q;
   assign pend_ts_o   = ts_q;
endmodule

module trace_capture_buffer #(
   parameter int NUM_CH = 3,
   parameter int DATA_W = 128,
   parameter int IDX_W  = 10,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 32,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     enable_i,
   input  logic [NUM_CH-1:0]        ch_valid_i,
   input  logic [NUM_CH*IDX_W-1:0]  ch_idx_i,
   input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [CH_W-1:0]          out_ch_o,
   output logic [IDX_W-1:0]         out_idx_o,
   output logic [DATA_W-1:0]        out_data_o,
   output logic [TS_W-1:0]          out_ts_o,
   output logic                     full_o,
   output logic [15:0]              drop_cnt_o
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [CH_W-1:0]   ch;
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
      logic [TS_W-1:0]   ts;
   } entry_t;

   logic [TS_W-1:0]                 ts_q;
   logic [CH_W-1:0]                 rr_q, rr_d;
   logic [AW:0]                     wr_q, wr_d, rd_q, rd_d;
   logic [15:0]                     drop_q, drop_d;
   entry_t                          mem_q [DEPTH];

   logic [NUM_CH-1:0]               pend_vld, move, drop;
   logic [NUM_CH-1:0][IDX_W-1:0]    pend_idx;
   logic [NUM_CH-1:0][DATA_W-1:0]   pend_data;
   logic [NUM_CH-1:0][TS_W-1:0]     pend_ts;

   logic                            gnt_found, push, pop, empty, full, space;
   logic [CH_W-1:0]                 gnt;
   logic [CH_W:0]                   cand;
   logic [4:0]                      ndrop;
   logic [16:0]                     drop_sum;
   entry_t                          head, wentry;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      assign move[c] = push && (gnt == CH_W'(c));

      trace_capture_lane #(.DATA_W(DATA_W), .IDX_W(IDX_W), .TS_W(TS_W)) u_lane (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .enable_i    (enable_i),
         .valid_i     (ch_valid_i[c]),
         .idx_i       (ch_idx_i[c*IDX_W +: IDX_W]),
         .data_i      (ch_data_i[c*DATA_W +: DATA_W]),
         .ts_i        (ts_q),
         .move_i      (move[c]),
         .pend_vld_o  (pend_vld[c]),
         .pend_idx_o  (pend_idx[c]),
         .pend_data_o (pend_data[c]),
         .pend_ts_o   (pend_ts[c]),
         .drop_o      (drop[c])
      );
   end

   // Round-robin search starting at rr_q, wrapping modulo NUM_CH.
   always_comb begin
      gnt_found = 1'b0;
      gnt       = '0;
      cand      = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = {1'b0, rr_q} + (CH_W+1)'(k);
         if (cand >= (CH_W+1)'(NUM_CH)) cand = cand - (CH_W+1)'(NUM_CH);
         if (!gnt_found && pend_vld[cand[CH_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt       = cand[CH_W-1:0];
         end
      end
   end

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop   = ~empty & out_ready_i;
   assign space = ~full | pop;
   assign push  = gnt_found & space;

   always_comb begin
      ndrop = '0;
      for (int c = 0; c < NUM_CH; c++) ndrop = ndrop + 5'(drop[c]);
   end

   assign drop_sum = {1'b0, drop_q} + 17'(ndrop);

   always_comb begin
      rr_d   = rr_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (push) begin
         wr_d = wr_q + 1'b1;
         rr_d = (gnt == CH_W'(NUM_CH-1)) ? '0 : gnt + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ts_q   <= '0;
         rr_q   <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         drop_q <= '0;
      end else begin
         if (enable_i) ts_q <= ts_q + TS_W'(1);
         rr_q   <= rr_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         drop_q <= drop_d;
      end
   end

   assign wentry = '{ch: gnt, idx: pend_idx[gnt], data: pend_data[gnt], ts: pend_ts[gnt]};

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_q[AW-1:0]] <= wentry;
   end

   // Head is forced to zero while empty so reset/idle outputs are defined.
   assign head        = empty ? '0 : mem_q[rd_q[AW-1:0]];
   assign out_valid_o = ~empty;
   assign out_ch_o    = head.ch;
   assign out_idx_o   = head.idx;
   assign out_data_o  = head.data;
   assign out_ts_o    = head.ts;
   assign full_o      = full;
   assign drop_cnt_o  = drop_q;
endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer with a pop-side scoreboard.
module tb_trace_capture_buffer;
   localparam int NUM_CH = 3;
   localparam int DATA_W = 128;
   localparam int IDX_W  = 10;
   localparam int DEPTH  = 16;
   localparam int TS_W   = 32;
   localparam int CH_W   = 2;

   logic                     clk = 1'b0;
   logic                     rst, enable, out_ready;
   logic [NUM_CH-1:0]        ch_valid;
   logic [NUM_CH*IDX_W-1:0]  ch_idx;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic                     out_valid, full;
   logic [CH_W-1:0]          out_ch;
   logic [IDX_W-1:0]         out_idx;
   logic [DATA_W-1:0]        out_data;
   logic [TS_W-1:0]          out_ts;
   logic [15:0]              drop_cnt;

   typedef struct packed {
      logic [CH_W-1:0]   ch;
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
      logic [TS_W-1:0]   ts;
   } exp_t;

   exp_t            sb[$];
   exp_t            mon_e;
   int              total = 0;
   int              bad = 0;
   int              npop = 0;
   int              p0;
   logic [TS_W-1:0] m_ts;
   logic [TS_W-1:0] t0;

   trace_capture_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .IDX_W(IDX_W),
                          .DEPTH(DEPTH), .TS_W(TS_W)) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable),
      .ch_valid_i(ch_valid), .ch_idx_i(ch_idx), .ch_data_i(ch_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ch_o(out_ch),
      .out_idx_o(out_idx), .out_data_o(out_data), .out_ts_o(out_ts),
      .full_o(full), .drop_cnt_o(drop_cnt)
   );

   always #5 clk = ~clk;

   // Reference cycle counter: the stamp an event driven now will carry.
   always @(posedge clk) begin
      if (rst) m_ts <= '0;
      else if (enable) m_ts <= m_ts + 1;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Handshake seen at negedge completes at the following posedge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         npop++;
         if (sb.size() == 0) chk("unexpected_pop", 128'(out_valid), 128'(0));
         else begin
            mon_e = sb.pop_front();
            chk("pop_ch",   128'(out_ch),   128'(mon_e.ch));
            chk("pop_idx",  128'(out_idx),  128'(mon_e.idx));
            chk("pop_data", 128'(out_data), 128'(mon_e.data));
            chk("pop_ts",   128'(out_ts),   128'(mon_e.ts));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ev(input int c, input int idx, input logic [DATA_W-1:0] d, input bit expect_it);
      exp_t e;
      ch_valid[c] = 1'b1;
      ch_idx[c*IDX_W +: IDX_W] = IDX_W'(idx);
      ch_data[c*DATA_W +: DATA_W] = d;
      e.ch = CH_W'(c);
      e.idx = IDX_W'(idx);
      e.data = d;
      e.ts = m_ts;
      if (expect_it) sb.push_back(e);
   endtask

   task automatic idle();
      ch_valid = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      out_ready = 1'b0;
      idle();
      sb.delete();
      tick();
      rst = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      out_ready = 1'b1;
      for (int i = 0; i < budget && sb.size() != 0; i++) tick();
      chk(tag, 128'(sb.size()), 128'(0));
      out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; enable = 1'b1; out_ready = 1'b0;
      ch_valid = '0; ch_idx = '0; ch_data = '0;
      tick(); tick();
      chk("rst_valid", 128'(out_valid), 128'(0));
      chk("rst_full",  128'(full),      128'(0));
      chk("rst_drop",  128'(drop_cnt),  128'(0));
      chk("rst_head",  128'({out_ch, out_idx, out_ts}), 128'(0));
      chk("rst_data",  out_data, 128'(0));
      rst = 1'b0;

      // Single event at ts=10, two-cycle latency
      for (int i = 0; i < 20 && m_ts != 10; i++) tick();
      ev(1, 5, 128'hA5, 1'b1);
      tick(); idle();
      chk("lat_not_yet", 128'(out_valid), 128'(0));
      tick();
      chk("single_valid", 128'(out_valid), 128'(1));
      chk("single_ch",    128'(out_ch),    128'(1));
      chk("single_idx",   128'(out_idx),   128'(5));
      chk("single_data",  out_data,        128'hA5);
      chk("single_ts",    128'(out_ts),    128'(10));
      drain("single_drain", 5);
      tick();
      chk("single_empty", 128'(out_valid), 128'(0));

      // All channels in one cycle drain in channel order with one stamp
      do_reset();
      out_ready = 1'b1;
      ev(0, 20, 128'h100, 1'b1);
      ev(1, 21, 128'h101, 1'b1);
      ev(2, 22, 128'h102, 1'b1);
      tick(); idle();
      p0 = npop;
      drain("rr_drain", 10);
      chk("rr_npop", 128'(npop - p0), 128'(3));

      // Back-pressure: fill FIFO, one parked in pending, three dropped
      do_reset();
      for (int k = 0; k < 20; k++) begin
         if (k == 0) t0 = m_ts;
         ev(0, 100 + k, 128'h1000 + 128'(k), k <= 16);
         tick();
      end
      idle();
      chk("bp_full",  128'(full),     128'(1));
      chk("bp_drop",  128'(drop_cnt), 128'(3));
      chk("bp_head",  128'(out_idx),  128'(100));
      tick(); tick();
      chk("bp_head_stable", 128'(out_idx), 128'(100));
      chk("bp_ts_stable",   128'(out_ts),  128'(t0));

      // Simultaneous push and pop at full
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pp_full", 128'(full),     128'(1));
      chk("pp_drop", 128'(drop_cnt), 128'(3));
      chk("pp_head", 128'(out_idx),  128'(101));
      drain("bp_drain", 40);
      tick();
      chk("bp_empty", 128'({out_valid, full}), 128'(0));

      // enable=0 ignores strobes and freezes ts without counting drops
      enable = 1'b0;
      ev(0, 1, 128'h55, 1'b0);
      tick(); tick(); idle(); tick();
      chk("dis_valid", 128'(out_valid), 128'(0));
      chk("dis_drop",  128'(drop_cnt),  128'(3));
      enable = 1'b1;
      ev(2, 7, 128'h77, 1'b1);
      tick(); idle();
      drain("dis_drain", 10);

      // Reset with queued entries
      do_reset();
      for (int k = 0; k < 8; k++) begin
         ev(1, 200 + k, 128'(k), 1'b1);
         tick();
      end
      idle(); tick(); tick();
      chk("q8_valid", 128'(out_valid), 128'(1));
      do_reset();
      chk("rst2_valid", 128'(out_valid), 128'(0));
      chk("rst2_drop",  128'(drop_cnt),  128'(0));
      ev(0, 9, 128'h99, 1'b1);
      tick(); idle(); tick();
      chk("rst2_ts", 128'(out_ts), 128'(0));
      drain("rst2_drain", 5);

      // Repeated event: filtered or not depending on build
      do_reset();
      out_ready = 1'b1;
      p0 = npop;
      ev(2, 3, 128'h7, 1'b1);
      tick();
`ifdef TRACE_FILTER_EN
      ev(2, 3, 128'h7, 1'b0);
`else
      ev(2, 3, 128'h7, 1'b1);
`endif
      tick();
      ev(2, 3, 128'h8, 1'b1);
      tick(); idle();
      drain("filt_drain", 10);
      tick();
`ifdef TRACE_FILTER_EN
      chk("filt_count", 128'(npop - p0), 128'(2));
`else
      chk("filt_count", 128'(npop - p0), 128'(3));
`endif

      // Multi-channel drops sum per cycle, then saturate
      do_reset();
      for (int i = 0; i < 23000; i++) begin
         ev(0, 1, 128'(i), 1'b0);
         ev(1, 2, 128'(i), 1'b0);
         ev(2, 3, 128'(i), 1'b0);
         tick();
         if (i == 19) chk("drop_sum", 128'(drop_cnt), 128'(41));
      end
      idle();
      chk("drop_sat", 128'(drop_cnt), 128'(16'hFFFF));
      do_reset();
      chk("drop_clr", 128'(drop_cnt), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
